// File: rtl/arb_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux_pkg
//  Description : Shared definitions for the arb_mux arbitrating multiplexer:
//                arbitration mode encodings, output-slot state encoding and
//                the select-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_mux_pkg;

    // Arbitration mode encodings (value of the MODE parameter)
    localparam int MODE_RR    = 0;  // round-robin, rotating pointer
    localparam int MODE_FIXED = 1;  // fixed priority, lowest index wins

    // Output slot occupancy
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    // Width of a channel index; never narrower than one bit so that a
    // single-channel instance still has a real select port.
    function automatic int calc_sel_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage : arb_mux_pkg
`default_nettype wire

// File: rtl/arb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational arbiter. In round-robin mode the search starts
//                at the supplied pointer and wraps modulo CHANNELS; in fixed
//                mode the lowest requesting index wins. Produces a one-hot
//                grant plus the binary index of the winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [SEL_W-1:0]    i_ptr,
    input  logic                i_en,
    input  logic                i_mode,   // 1 = fixed priority
    output logic [CHANNELS-1:0] o_grant,
    output logic [SEL_W-1:0]    o_idx
);

    // Walk the channels in search order and grant the first requester found.
    // The inner loop compares against constant indices so the request vector
    // is never indexed by a variable wider or narrower than it needs.
    always_comb begin
        logic found;
        found   = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            int cand;
            if (i_mode) begin
                cand = i;
            end else begin
                cand = int'(i_ptr) + i;
                if (cand >= CHANNELS) begin
                    cand = cand - CHANNELS;
                end
            end
            for (int j = 0; j < CHANNELS; j++) begin
                if (i_en && !found && (j == cand) && i_req[j]) begin
                    found      = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = SEL_W'(j);
                end
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux
//  Description : N-channel valid/ready arbitrating multiplexer with a single
//                registered output slot. Sustains one word per cycle when the
//                consumer is ready; winner chosen by round-robin or fixed
//                priority as selected by MODE.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int MODE     = MODE_RR
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [CHANNELS*WIDTH-1:0]    I_DATA,
    input  logic [CHANNELS-1:0]          I_VALID,
    output logic [CHANNELS-1:0]          I_READY,
    output logic [WIDTH-1:0]             Y,
    output logic                         Y_VALID,
    input  logic                         Y_READY,
    output logic [calc_sel_w(CHANNELS)-1:0] Y_SEL
);

    localparam int SEL_W = calc_sel_w(CHANNELS);

    // Registered state
    slot_state_e        state_q, state_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [SEL_W-1:0]   ptr_q,   ptr_d;

    // Combinational handshake signals
    logic                w_slot_free;
    logic                w_arb_en;
    logic                w_take;
    logic [CHANNELS-1:0] w_grant;
    logic [SEL_W-1:0]    w_idx;
    logic [WIDTH-1:0]    w_win_data;

    // The slot can take a word when empty, or when full and draining this
    // cycle. Reset blocks every grant so nothing is accepted and then lost.
    always_comb begin
        w_slot_free = (state_q == ST_EMPTY) || Y_READY;
        w_arb_en    = w_slot_free && !RST;
    end

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_arbiter (
        .i_req   (I_VALID),
        .i_ptr   (ptr_q),
        .i_en    (w_arb_en),
        .i_mode  (MODE == MODE_FIXED),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // Grant is also the per-channel ready; a transfer happens on any grant
    // because the arbiter only grants requesting channels.
    always_comb begin
        I_READY    = w_grant;
        w_take     = |w_grant;
        w_win_data = I_DATA[int'(w_idx)*WIDTH +: WIDTH];
    end

    // Next-state for slot occupancy, captured word, source index and pointer.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (w_take) begin
            state_d = ST_FULL;
            data_d  = w_win_data;
            sel_d   = w_idx;
            if (MODE == MODE_RR) begin
                if (int'(w_idx) == CHANNELS - 1) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = w_idx + 1'b1;
                end
            end
        end else if ((state_q == ST_FULL) && Y_READY) begin
            state_d = ST_EMPTY;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    // Output drive straight from the slot registers.
    always_comb begin
        Y       = data_q;
        Y_VALID = (state_q == ST_FULL);
        Y_SEL   = sel_q;
    end

endmodule : arb_mux
`default_nettype wire
